// File: rtl/aes_stream_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_stream_gearbox
//  Description : Word/block gearbox between the 32-bit streamer word streams
//                and the 128-bit AES core. The pack side gathers words into a
//                zero-padded block. The unpack side serialises a result block
//                back into words. The two sides share no state.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_stream_gearbox #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  // word input stream
  input  logic [WORD_W-1:0]                 in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  // block toward core
  output logic [WORD_W*NWORDS-1:0]          blk_data,
  output logic [$clog2(NWORDS+1)-1:0]       blk_nwords,
  output logic                              blk_last,
  output logic                              blk_valid,
  input  logic                              blk_ready,
  // result block from core
  input  logic [WORD_W*NWORDS-1:0]          res_data,
  input  logic [$clog2(NWORDS+1)-1:0]       res_nwords,
  input  logic                              res_last,
  input  logic                              res_valid,
  output logic                              res_ready,
  // word output stream
  output logic [WORD_W-1:0]                 out_data,
  output logic                              out_valid,
  output logic                              out_last,
  input  logic                              out_ready
);

  localparam int BLK_W = WORD_W * NWORDS;
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NW_W  = $clog2(NWORDS + 1);

  localparam logic [0:0] PK_FILL  = 1'b0;
  localparam logic [0:0] PK_FULL  = 1'b1;
  localparam logic [0:0] UP_EMPTY = 1'b0;
  localparam logic [0:0] UP_DRAIN = 1'b1;

  // --------------------------------------------------------------------------
  // Pack side
  // --------------------------------------------------------------------------
  logic [0:0]       pk_state;
  logic [CNT_W-1:0] pk_cnt;
  logic [BLK_W-1:0] pk_blk_next;
  logic             pk_fire;
  logic             pk_done;

  assign in_ready  = (pk_state == PK_FILL);
  assign blk_valid = (pk_state == PK_FULL);
  assign pk_fire   = in_valid && in_ready;
  assign pk_done   = (pk_cnt == CNT_W'(NWORDS - 1)) || in_last;

  // Insert the incoming word into slot pk_cnt; word 0 lives in the MSBs.
  // Slots not yet written are already zero because the block register is
  // cleared whenever a block leaves, which provides the zero padding.
  always_comb begin
    pk_blk_next = blk_data;
    for (int i = 0; i < NWORDS; i++) begin
      if (pk_cnt == CNT_W'(i)) begin
        pk_blk_next[BLK_W-1-i*WORD_W -: WORD_W] = in_data;
      end
    end
  end

  // Pack FSM: fill slots until full or last word, then hold until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_state   <= PK_FILL;
      pk_cnt     <= '0;
      blk_data   <= '0;
      blk_nwords <= '0;
      blk_last   <= 1'b0;
    end else if (clear) begin
      pk_state   <= PK_FILL;
      pk_cnt     <= '0;
      blk_data   <= '0;
      blk_nwords <= '0;
      blk_last   <= 1'b0;
    end else begin
      case (pk_state)
        PK_FILL: begin
          if (pk_fire) begin
            blk_data <= pk_blk_next;
            if (pk_done) begin
              pk_state   <= PK_FULL;
              blk_nwords <= NW_W'(pk_cnt) + NW_W'(1);
              blk_last   <= in_last;
              pk_cnt     <= '0;
            end else begin
              pk_cnt <= pk_cnt + CNT_W'(1);
            end
          end
        end
        PK_FULL: begin
          if (blk_ready) begin
            pk_state   <= PK_FILL;
            blk_data   <= '0;
            blk_nwords <= '0;
            blk_last   <= 1'b0;
          end
        end
        default: begin
          pk_state <= PK_FILL;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Unpack side
  // --------------------------------------------------------------------------
  logic [0:0]       up_state;
  logic [CNT_W-1:0] up_cnt;
  logic [BLK_W-1:0] up_data;
  logic [NW_W-1:0]  up_nwords;
  logic             up_last;
  logic [NW_W-1:0]  res_nw_clamped;
  logic             up_final;

  assign res_ready = (up_state == UP_EMPTY);
  assign out_valid = (up_state == UP_DRAIN);
  assign up_final  = (NW_W'(up_cnt) == (up_nwords - NW_W'(1)));
  assign out_last  = out_valid && up_final && up_last;

  // A zero word count means a full block; anything above a full block is
  // clamped so the drain counter never runs past the last slot.
  assign res_nw_clamped = ((res_nwords == '0) || (res_nwords > NW_W'(NWORDS)))
                        ? NW_W'(NWORDS) : res_nwords;

  // Select the latched word addressed by the drain counter.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (up_cnt == CNT_W'(i)) begin
        out_data = up_data[BLK_W-1-i*WORD_W -: WORD_W];
      end
    end
  end

  // Unpack FSM: latch a result block, then drain it one word per transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_state  <= UP_EMPTY;
      up_cnt    <= '0;
      up_data   <= '0;
      up_nwords <= '0;
      up_last   <= 1'b0;
    end else if (clear) begin
      up_state  <= UP_EMPTY;
      up_cnt    <= '0;
      up_data   <= '0;
      up_nwords <= '0;
      up_last   <= 1'b0;
    end else begin
      case (up_state)
        UP_EMPTY: begin
          if (res_valid) begin
            up_state  <= UP_DRAIN;
            up_cnt    <= '0;
            up_data   <= res_data;
            up_nwords <= res_nw_clamped;
            up_last   <= res_last;
          end
        end
        UP_DRAIN: begin
          if (out_ready) begin
            if (up_final) begin
              up_state  <= UP_EMPTY;
              up_cnt    <= '0;
              up_data   <= '0;
              up_nwords <= '0;
              up_last   <= 1'b0;
            end else begin
              up_cnt <= up_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          up_state <= UP_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
